d_router: RTL and testbench
===========================

# d_router

Parametrised data-side bus router between the core's load/store port and up to N_TGT memory-mapped targets (RAM, register banks, peripherals). Decodes each request against per-target base/mask windows, forwards a single-cycle enable with the target-relative offset, and waits for a target-specific ready. Adds what the single-RAM/single-reg mux lacks: variable-latency write handshake, decode-error and timeout responses, and one outstanding transaction tracked by a small FSM.

## Interface
- XLEN, 32, data width (multiple of 8)
- ADDR_LEN, 14, byte address width
- N_TGT, 4, number of targets (1..8)
- TGT_BASE, {N_TGT{ADDR_LEN'h0}}, packed base address per target, index i at [i*ADDR_LEN +: ADDR_LEN]
- TGT_MASK, {N_TGT{ADDR_LEN'h0}}, packed decode mask per target; hit when (addr & MASK_i) == BASE_i
- TIMEOUT, 15, wait cycles before error response (>=2)
- ERR_RDATA, 32'hDEAD_BEEF, rd_data returned on error, truncated or zero-extended to XLEN
- clk  in  1  clock
- rstb  in  1  reset; asynchronous, active-low
- addr  in  ADDR_LEN  byte address, valid with rd_req/wr_req
- rd_req  in  1  read request, single-cycle pulse
- wr_req  in  1  write request, single-cycle pulse
- wr_be  in  XLEN/8  write byte enables
- wr_data  in  XLEN  write data
- rd_ready  out  1  read completion pulse
- wr_ready  out  1  write completion pulse
- rd_data  out  XLEN  read data, valid while rd_ready=1
- err  out  1  error flag, valid with rd_ready/wr_ready
- t_addr  out  N_TGT*ADDR_LEN  per-target offset (addr - BASE_i)
- t_rd_en  out  N_TGT  per-target read enable pulse
- t_wr_en  out  N_TGT  per-target write enable pulse
- t_wr_be  out  N_TGT*XLEN/8  per-target byte enables (zero when not selected)
- t_wr_data  out  XLEN  shared write data
- t_rd_data  in  N_TGT*XLEN  per-target read data
- t_rd_ready  in  N_TGT  per-target read completion
- t_wr_ready  in  N_TGT  per-target write completion

## Operation
- FSM states IDLE, RD_WAIT, WR_WAIT, ERR_RESP.
- Decode: lowest-index hitting target wins; no hit -> decode error.
- IDLE + wr_req: hit -> t_wr_en[sel]=1, t_wr_be[sel]=wr_be this cycle, latch sel/offset/be/data, go WR_WAIT; miss -> go ERR_RESP (write).
- IDLE + rd_req: same with t_rd_en, RD_WAIT. wr_req and rd_req together: write serviced, read dropped.
- RD_WAIT: rd_ready = t_rd_ready[sel], rd_data = t_rd_data[sel] (combinational forward), err=0 -> IDLE. WR_WAIT likewise with t_wr_ready/wr_ready.
- Wait counter counts cycles in *_WAIT; reaching TIMEOUT with no ready -> ready pulse with err=1 (rd_data=ERR_RDATA) that cycle -> IDLE.
- ERR_RESP: one cycle, ready pulse of latched kind with err=1, rd_data=ERR_RDATA -> IDLE.
- Requests outside IDLE ignored (protocol violation). Ready from non-selected targets, or any ready in IDLE, ignored.
- t_addr/t_wr_data: live values in acceptance cycle, latched values in wait states. Offset subtraction modulo 2^ADDR_LEN.

## Timing
- Reset: state IDLE, counter 0, all latches 0; every output 0 except t_addr = offsets of addr input.
- Minimum latency: request cycle N, target ready N+1 -> rd_ready/wr_ready N+1. Decode error: ready+err at N+1.
- Timeout: ready+err at cycle N+TIMEOUT.
- Ready and timeout same cycle: ready wins, err=0.
- New request accepted the cycle after completion (back-to-back, one per 2 cycles min).
- rstb asserted mid-transaction: abort immediately, no ready pulse.

## Structure
- d_bus_pkg: state enum, ERR_RDATA default, helper function for packed-slice extraction.
- Sub-module d_addr_decode: combinational base/mask compare + priority encoder -> hit, sel index, offset.

## Test plan
- Read RAM at target 1 (BASE 0x1000, MASK 0x3000), addr 0x1008, ready at N+1 with 0x1234_5678 -> t_rd_en[1] at N, t_addr=0x008, rd_ready N+1, rd_data 0x1234_5678, err 0.
- Write be=4'b0011 to target 0, ready withheld 3 cycles -> t_wr_be[0]=0011 one cycle, wr_ready at N+4, err 0.
- Unmapped address read -> no t_rd_en, rd_ready N+1, err 1, rd_data 0xDEAD_BEEF.
- Target never ready, TIMEOUT=15 -> rd_ready+err at N+15; ready arriving exactly N+15 -> err 0.
- Simultaneous rd_req/wr_req; request during wait; rstb pulsed in RD_WAIT -> write only; ignored; no ready, outputs zero, IDLE.

Source files
------------

// File: rtl/d_router_pkg.sv
// Shared types, constants and helpers for the data-side bus router.
package d_router_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_WAIT  = 2'd1,
        ST_WR_WAIT  = 2'd2,
        ST_ERR_RESP = 2'd3
    } state_t;

    localparam logic [31:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;

    // Lowest bit of field idx in a vector packed from equal-width fields.
    function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/d_router_if.sv
// Core load/store port plus per-target fan-out of the data-side router.
interface d_router_if #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ADDR_LEN = 14,
    parameter int unsigned N_TGT    = 4
);
    localparam int unsigned BE_W = XLEN / 8;

    logic [ADDR_LEN-1:0]       addr;
    logic                      rd_req;
    logic                      wr_req;
    logic [BE_W-1:0]           wr_be;
    logic [XLEN-1:0]           wr_data;
    logic                      rd_ready;
    logic                      wr_ready;
    logic [XLEN-1:0]           rd_data;
    logic                      err;

    logic [N_TGT*ADDR_LEN-1:0] t_addr;
    logic [N_TGT-1:0]          t_rd_en;
    logic [N_TGT-1:0]          t_wr_en;
    logic [N_TGT*BE_W-1:0]     t_wr_be;
    logic [XLEN-1:0]           t_wr_data;
    logic [N_TGT*XLEN-1:0]     t_rd_data;
    logic [N_TGT-1:0]          t_rd_ready;
    logic [N_TGT-1:0]          t_wr_ready;

    // Router side.
    modport slave (
        input  addr, rd_req, wr_req, wr_be, wr_data,
        output rd_ready, wr_ready, rd_data, err,
        output t_addr, t_rd_en, t_wr_en, t_wr_be, t_wr_data,
        input  t_rd_data, t_rd_ready, t_wr_ready
    );

    // Core and target side.
    modport master (
        output addr, rd_req, wr_req, wr_be, wr_data,
        input  rd_ready, wr_ready, rd_data, err,
        input  t_addr, t_rd_en, t_wr_en, t_wr_be, t_wr_data,
        output t_rd_data, t_rd_ready, t_wr_ready
    );

endinterface

// File: rtl/d_router_addr_decode.sv
// Base/mask window compare with lowest-index priority, plus per-target offsets.
module d_router_addr_decode
    import d_router_pkg::*;
#(
    parameter int unsigned             ADDR_LEN = 14,
    parameter int unsigned             N_TGT    = 4,
    parameter int unsigned             SEL_W    = 2,
    parameter logic [N_TGT*ADDR_LEN-1:0] TGT_BASE = '0,
    parameter logic [N_TGT*ADDR_LEN-1:0] TGT_MASK = '0
) (
    input  logic [ADDR_LEN-1:0]       i_addr,
    output logic                      o_hit,
    output logic [SEL_W-1:0]          o_sel,
    output logic [N_TGT*ADDR_LEN-1:0] o_offset
);

    logic [N_TGT-1:0] w_match;

    // Window match and modular offset for every target.
    always_comb begin
        w_match  = '0;
        o_offset = '0;
        for (int unsigned i = 0; i < N_TGT; i++) begin
            w_match[i] = (i_addr & TGT_MASK[slice_lo(i, ADDR_LEN) +: ADDR_LEN])
                         == TGT_BASE[slice_lo(i, ADDR_LEN) +: ADDR_LEN];
            o_offset[slice_lo(i, ADDR_LEN) +: ADDR_LEN] =
                i_addr - TGT_BASE[slice_lo(i, ADDR_LEN) +: ADDR_LEN];
        end
    end

    // Overlapping windows resolve to the lowest index.
    always_comb begin
        o_hit = 1'b0;
        o_sel = '0;
        for (int unsigned i = 0; i < N_TGT; i++) begin
            if (w_match[i] && !o_hit) begin
                o_hit = 1'b1;
                o_sel = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/d_router.sv
// Data-side bus router: decodes core requests onto N_TGT targets, one outstanding
// transaction, with variable-latency completion, decode-error and timeout responses.
module d_router
    import d_router_pkg::*;
#(
    parameter int unsigned               XLEN      = 32,
    parameter int unsigned               ADDR_LEN  = 14,
    parameter int unsigned               N_TGT     = 4,
    parameter logic [N_TGT*ADDR_LEN-1:0] TGT_BASE  = '0,
    parameter logic [N_TGT*ADDR_LEN-1:0] TGT_MASK  = '0,
    parameter int unsigned               TIMEOUT   = 15,
    parameter logic [31:0]               ERR_RDATA = ERR_RDATA_DEF
) (
    input  logic       clk,
    input  logic       rstb,
    d_router_if.slave  bus
);

    localparam int unsigned   BE_W     = XLEN / 8;
    localparam int unsigned   SEL_W    = (N_TGT > 1) ? $clog2(N_TGT) : 1;
    localparam int unsigned   CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [XLEN-1:0] ERR_WORD = XLEN'(ERR_RDATA);

    state_t                    r_state;
    state_t                    w_next;
    logic [SEL_W-1:0]          r_sel;
    logic [ADDR_LEN-1:0]       r_addr;
    logic [XLEN-1:0]           r_data;
    logic                      r_is_wr;
    logic [CNT_W-1:0]          r_cnt;

    logic [ADDR_LEN-1:0]       w_dec_addr;
    logic                      w_hit;
    logic [SEL_W-1:0]          w_sel;
    logic [N_TGT*ADDR_LEN-1:0] w_offset;
    logic                      w_tgt_rd_rdy;
    logic                      w_tgt_wr_rdy;
    logic                      w_timeout;
    logic [XLEN-1:0]           w_tgt_rdata;

    // Live address decides in IDLE; the latched one drives offsets while waiting.
    assign w_dec_addr = (r_state == ST_IDLE) ? bus.addr : r_addr;

    d_router_addr_decode #(
        .ADDR_LEN (ADDR_LEN),
        .N_TGT    (N_TGT),
        .SEL_W    (SEL_W),
        .TGT_BASE (TGT_BASE),
        .TGT_MASK (TGT_MASK)
    ) u_decode (
        .i_addr   (w_dec_addr),
        .o_hit    (w_hit),
        .o_sel    (w_sel),
        .o_offset (w_offset)
    );

    assign w_tgt_rd_rdy = bus.t_rd_ready[r_sel];
    assign w_tgt_wr_rdy = bus.t_wr_ready[r_sel];
    assign w_tgt_rdata  = bus.t_rd_data[slice_lo(32'(r_sel), XLEN) +: XLEN];
    assign w_timeout    = (r_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.wr_req) begin
                    w_next = w_hit ? ST_WR_WAIT : ST_ERR_RESP;
                end else if (bus.rd_req) begin
                    w_next = w_hit ? ST_RD_WAIT : ST_ERR_RESP;
                end
            end
            ST_RD_WAIT: begin
                if (w_tgt_rd_rdy || w_timeout) begin
                    w_next = ST_IDLE;
                end
            end
            ST_WR_WAIT: begin
                if (w_tgt_wr_rdy || w_timeout) begin
                    w_next = ST_IDLE;
                end
            end
            ST_ERR_RESP: w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    // Target ready beats a coincident timeout.
    always_comb begin
        bus.rd_ready  = 1'b0;
        bus.wr_ready  = 1'b0;
        bus.rd_data   = '0;
        bus.err       = 1'b0;
        bus.t_addr    = w_offset;
        bus.t_rd_en   = '0;
        bus.t_wr_en   = '0;
        bus.t_wr_be   = '0;
        bus.t_wr_data = '0;
        case (r_state)
            ST_IDLE: begin
                if (bus.wr_req) begin
                    if (w_hit) begin
                        bus.t_wr_en[w_sel] = 1'b1;
                        bus.t_wr_be[slice_lo(32'(w_sel), BE_W) +: BE_W] = bus.wr_be;
                        bus.t_wr_data = bus.wr_data;
                    end
                end else if (bus.rd_req && w_hit) begin
                    bus.t_rd_en[w_sel] = 1'b1;
                end
            end
            ST_RD_WAIT: begin
                if (w_tgt_rd_rdy) begin
                    bus.rd_ready = 1'b1;
                    bus.rd_data  = w_tgt_rdata;
                end else if (w_timeout) begin
                    bus.rd_ready = 1'b1;
                    bus.err      = 1'b1;
                    bus.rd_data  = ERR_WORD;
                end
            end
            ST_WR_WAIT: begin
                bus.t_wr_data = r_data;
                if (w_tgt_wr_rdy) begin
                    bus.wr_ready = 1'b1;
                end else if (w_timeout) begin
                    bus.wr_ready = 1'b1;
                    bus.err      = 1'b1;
                    bus.rd_data  = ERR_WORD;
                end
            end
            ST_ERR_RESP: begin
                bus.err      = 1'b1;
                bus.rd_data  = ERR_WORD;
                bus.wr_ready = r_is_wr;
                bus.rd_ready = !r_is_wr;
            end
            default: begin
                bus.err = 1'b0;
            end
        endcase
    end

    // Transaction context captured at acceptance; wait counter runs in wait states.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_sel   <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_is_wr <= 1'b0;
            r_cnt   <= '0;
        end else if (r_state == ST_IDLE) begin
            r_cnt <= '0;
            if (bus.wr_req || bus.rd_req) begin
                r_sel   <= w_sel;
                r_addr  <= bus.addr;
                r_is_wr <= bus.wr_req;
                r_data  <= bus.wr_req ? bus.wr_data : '0;
            end
        end else if ((r_state == ST_RD_WAIT) || (r_state == ST_WR_WAIT)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_d_router.sv
// Randomized and directed bench for d_router against a transaction-level model.
module tb_d_router;

    localparam int unsigned TMO = 15;
    localparam logic [13:0] BASE [4] = '{14'h0000, 14'h1000, 14'h2000, 14'h2000};
    localparam logic [13:0] MASK [4] = '{14'h3000, 14'h3000, 14'h3800, 14'h3000};
    localparam logic [31:0] DEAD = 32'hDEAD_BEEF;

    typedef struct {
        logic [3:0]  rd_en, wr_en;
        logic [15:0] wbe, w_wbe;
        logic [55:0] taddr, w_taddr;
        logic [31:0] wdata, w_wdata, rdata;
        logic        err, rd_rdy, wr_rdy, stray, inj_en;
        int          done;
    } obs_t;

    logic clk = 1'b0;
    logic rstb;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    d_router_if #(.XLEN(32), .ADDR_LEN(14), .N_TGT(4)) bus ();

    d_router #(
        .XLEN     (32),
        .ADDR_LEN (14),
        .N_TGT    (4),
        .TGT_BASE ({14'h2000, 14'h2000, 14'h1000, 14'h0000}),
        .TGT_MASK ({14'h3000, 14'h3800, 14'h3000, 14'h3000}),
        .TIMEOUT  (TMO),
        .ERR_RDATA(32'hDEAD_BEEF)
    ) dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus)
    );

    function automatic int model_sel(input logic [13:0] a);
        for (int i = 0; i < 4; i++) if ((a & MASK[i]) == BASE[i]) return i;
        return -1;
    endfunction

    function automatic logic [55:0] exp_offsets(input logic [13:0] a);
        logic [55:0] v;
        for (int i = 0; i < 4; i++) v[i*14 +: 14] = a - BASE[i];
        return v;
    endfunction

    task automatic idle_inputs();
        bus.addr = '0; bus.rd_req = 1'b0; bus.wr_req = 1'b0; bus.wr_be = '0; bus.wr_data = '0;
        bus.t_rd_data = '0; bus.t_rd_ready = '0; bus.t_wr_ready = '0;
    endtask

    // One transaction: request at cycle 0, selected target answers at cycle dly (0 = never).
    task automatic drive_txn(input bit wr, input bit rd, input logic [13:0] a, input logic [3:0] be,
                             input logic [31:0] wd, input logic [31:0] td, input int dly,
                             input bit noise, input bit inject, output obs_t o);
        int sel;
        logic [3:0] rr, wrr;
        sel = model_sel(a);
        @(posedge clk); #1;
        bus.addr = a; bus.rd_req = rd; bus.wr_req = wr; bus.wr_be = be; bus.wr_data = wd;
        bus.t_rd_ready = '0; bus.t_wr_ready = '0;
        bus.t_rd_data = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        o.rd_en = bus.t_rd_en; o.wr_en = bus.t_wr_en; o.wbe = bus.t_wr_be;
        o.taddr = bus.t_addr; o.wdata = bus.t_wr_data;
        o.stray = bus.rd_ready | bus.wr_ready;
        o.done = -1; o.inj_en = 1'b0; o.rdata = '0; o.err = 1'b0; o.rd_rdy = 1'b0; o.wr_rdy = 1'b0;
        o.w_wbe = '0; o.w_taddr = '0; o.w_wdata = '0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            bus.rd_req = inject && (k == 2);
            bus.wr_req = inject && (k == 2);
            bus.addr = (inject && (k == 2)) ? a : 14'($urandom);
            bus.wr_data = $urandom; bus.wr_be = 4'($urandom);
            rr  = noise ? 4'($urandom) : 4'h0;
            wrr = noise ? 4'($urandom) : 4'h0;
            bus.t_rd_data = {$urandom, $urandom, $urandom, $urandom};
            if (sel >= 0) begin
                if (wr) wrr[sel] = (k == dly);
                else    rr[sel]  = (k == dly);
                bus.t_rd_data[sel*32 +: 32] = td;
            end
            bus.t_rd_ready = rr; bus.t_wr_ready = wrr;
            @(negedge clk);
            if (k == 1) begin
                o.w_taddr = bus.t_addr; o.w_wdata = bus.t_wr_data; o.w_wbe = bus.t_wr_be;
            end
            if (inject && (k == 2)) o.inj_en = |{bus.t_rd_en, bus.t_wr_en};
            if (bus.rd_ready || bus.wr_ready) begin
                if (o.done < 0) begin
                    o.done = k; o.rdata = bus.rd_data; o.err = bus.err;
                    o.rd_rdy = bus.rd_ready; o.wr_rdy = bus.wr_ready;
                end else begin
                    o.stray = 1'b1;
                end
            end
            if ((o.done >= 0) && (k >= dly)) break;
        end
    endtask

    task automatic test_reset();
        rstb = 1'b0;
        idle_inputs();
        bus.addr = 14'h1008; bus.wr_data = 32'h5555_AAAA; bus.wr_be = 4'hF;
        bus.t_rd_ready = 4'hF; bus.t_wr_ready = 4'hF; bus.t_rd_data = {4{32'h1111_2222}};
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if ({bus.rd_ready, bus.wr_ready, bus.err} !== 3'b000) begin n_fail++; $display("FAIL reset_ready got %b want 000", {bus.rd_ready, bus.wr_ready, bus.err}); end
        n_checks++; if (bus.rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_rd_data got %h want 0", bus.rd_data); end
        n_checks++; if ({bus.t_rd_en, bus.t_wr_en, bus.t_wr_be} !== 24'h0) begin n_fail++; $display("FAIL reset_enables got %h want 0", {bus.t_rd_en, bus.t_wr_en, bus.t_wr_be}); end
        n_checks++; if (bus.t_wr_data !== 32'h0) begin n_fail++; $display("FAIL reset_t_wr_data got %h want 0", bus.t_wr_data); end
        n_checks++; if (bus.t_addr !== exp_offsets(14'h1008)) begin n_fail++; $display("FAIL reset_t_addr got %h want %h", bus.t_addr, exp_offsets(14'h1008)); end
        #2 rstb = 1'b1;
        // Readies with nothing outstanding must be ignored.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++; if ({bus.rd_ready, bus.wr_ready} !== 2'b00) begin n_fail++; $display("FAIL idle_ready got %b want 00", {bus.rd_ready, bus.wr_ready}); end
        end
        idle_inputs();
    endtask

    task automatic test_read_ram();
        obs_t o;
        drive_txn(1'b0, 1'b1, 14'h1008, 4'h0, 32'h0, 32'h1234_5678, 1, 1'b0, 1'b0, o);
        n_checks++; if (o.rd_en !== 4'b0010) begin n_fail++; $display("FAIL rd_ram_en got %b want 0010", o.rd_en); end
        n_checks++; if (o.taddr[14 +: 14] !== 14'h008) begin n_fail++; $display("FAIL rd_ram_t_addr got %h want 008", o.taddr[14 +: 14]); end
        n_checks++; if (o.done !== 1) begin n_fail++; $display("FAIL rd_ram_latency got %0d want 1", o.done); end
        n_checks++; if ({o.rd_rdy, o.err, o.rdata} !== {2'b10, 32'h1234_5678}) begin n_fail++; $display("FAIL rd_ram_resp got %b%b %h want 10 12345678", o.rd_rdy, o.err, o.rdata); end
    endtask

    task automatic test_write_wait();
        obs_t o;
        drive_txn(1'b1, 1'b0, 14'h0010, 4'b0011, 32'hA5A5_1234, 32'h0, 4, 1'b1, 1'b0, o);
        n_checks++; if (o.wr_en !== 4'b0001) begin n_fail++; $display("FAIL wr_wait_en got %b want 0001", o.wr_en); end
        n_checks++; if (o.wbe !== 16'h0003) begin n_fail++; $display("FAIL wr_wait_be got %h want 0003", o.wbe); end
        n_checks++; if (o.w_wbe !== 16'h0000) begin n_fail++; $display("FAIL wr_wait_be_hold got %h want 0000", o.w_wbe); end
        n_checks++; if ({o.wdata, o.w_wdata} !== {2{32'hA5A5_1234}}) begin n_fail++; $display("FAIL wr_wait_data got %h/%h want a5a51234", o.wdata, o.w_wdata); end
        n_checks++; if (o.done !== 4) begin n_fail++; $display("FAIL wr_wait_latency got %0d want 4", o.done); end
        n_checks++; if ({o.wr_rdy, o.rd_rdy, o.err, o.stray} !== 4'b1000) begin n_fail++; $display("FAIL wr_wait_resp got %b want 1000", {o.wr_rdy, o.rd_rdy, o.err, o.stray}); end
    endtask

    task automatic test_decode_err();
        obs_t o;
        drive_txn(1'b0, 1'b1, 14'h3ABC, 4'h0, 32'h0, 32'h0, 0, 1'b1, 1'b0, o);
        n_checks++; if ({o.rd_en, o.wr_en} !== 8'h00) begin n_fail++; $display("FAIL derr_rd_en got %h want 00", {o.rd_en, o.wr_en}); end
        n_checks++; if (o.done !== 1) begin n_fail++; $display("FAIL derr_rd_latency got %0d want 1", o.done); end
        n_checks++; if ({o.rd_rdy, o.err, o.rdata} !== {2'b11, DEAD}) begin n_fail++; $display("FAIL derr_rd_resp got %b%b %h want 11 deadbeef", o.rd_rdy, o.err, o.rdata); end
        drive_txn(1'b1, 1'b0, 14'h3FFC, 4'hF, 32'h0BAD_F00D, 32'h0, 0, 1'b0, 1'b0, o);
        n_checks++; if (o.wr_en !== 4'h0) begin n_fail++; $display("FAIL derr_wr_en got %b want 0000", o.wr_en); end
        n_checks++; if ({o.done == 1, o.wr_rdy, o.rd_rdy, o.err} !== 4'b1101) begin n_fail++; $display("FAIL derr_wr_resp got done=%0d %b want done=1 101", o.done, {o.wr_rdy, o.rd_rdy, o.err}); end
    endtask

    task automatic test_timeout();
        obs_t o;
        drive_txn(1'b0, 1'b1, 14'h2040, 4'h0, 32'h0, 32'h0, 0, 1'b0, 1'b0, o);
        n_checks++; if (o.done !== int'(TMO)) begin n_fail++; $display("FAIL tmo_latency got %0d want %0d", o.done, TMO); end
        n_checks++; if ({o.rd_rdy, o.err, o.rdata} !== {2'b11, DEAD}) begin n_fail++; $display("FAIL tmo_resp got %b%b %h want 11 deadbeef", o.rd_rdy, o.err, o.rdata); end
        drive_txn(1'b0, 1'b1, 14'h2040, 4'h0, 32'h0, 32'h0000_CAFE, int'(TMO), 1'b0, 1'b0, o);
        n_checks++; if ({o.done == int'(TMO), o.rd_rdy, o.err, o.rdata} !== {3'b110, 32'h0000_CAFE}) begin n_fail++; $display("FAIL tmo_race got done=%0d %b%b %h want done=%0d 10 0000cafe", o.done, o.rd_rdy, o.err, o.rdata, TMO); end
        drive_txn(1'b1, 1'b0, 14'h2C00, 4'h1, 32'h7, 32'h0, int'(TMO) + 1, 1'b0, 1'b0, o);
        n_checks++; if ({o.done == int'(TMO), o.wr_rdy, o.err, o.stray} !== 4'b1110) begin n_fail++; $display("FAIL tmo_late_ready got done=%0d %b want done=%0d 110", o.done, {o.wr_rdy, o.err, o.stray}, TMO); end
    endtask

    task automatic test_simultaneous();
        obs_t o;
        drive_txn(1'b1, 1'b1, 14'h1100, 4'hF, 32'h0102_0304, 32'h0, 2, 1'b0, 1'b0, o);
        n_checks++; if ({o.wr_en, o.rd_en} !== 8'b0010_0000) begin n_fail++; $display("FAIL simul_en got %b want 00100000", {o.wr_en, o.rd_en}); end
        n_checks++; if ({o.done == 2, o.wr_rdy, o.rd_rdy, o.err} !== 4'b1100) begin n_fail++; $display("FAIL simul_resp got done=%0d %b want done=2 100", o.done, {o.wr_rdy, o.rd_rdy, o.err}); end
    endtask

    task automatic test_req_during_wait();
        obs_t o;
        drive_txn(1'b0, 1'b1, 14'h0200, 4'h0, 32'h0, 32'h0F0F_0F0F, 5, 1'b0, 1'b1, o);
        n_checks++; if (o.inj_en !== 1'b0) begin n_fail++; $display("FAIL inject_en got %b want 0", o.inj_en); end
        n_checks++; if ({o.done == 5, o.rd_rdy, o.err, o.stray, o.rdata} !== {4'b1100, 32'h0F0F_0F0F}) begin n_fail++; $display("FAIL inject_resp got done=%0d %h want done=5 0f0f0f0f", o.done, o.rdata); end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        logic [13:0] a;
        for (int n = 0; n < 4; n++) begin
            a = 14'($urandom_range(0, 16'h2FFF));
            drive_txn(n[0], !n[0], a, 4'hF, $urandom, 32'h0000_0100 + 32'(n), 1, 1'b1, 1'b0, o);
            n_checks++; if ({o.done == 1, o.err, o.stray, o.wr_rdy} !== {3'b100, n[0]}) begin n_fail++; $display("FAIL b2b_%0d got done=%0d err=%b stray=%b wr=%b", n, o.done, o.err, o.stray, o.wr_rdy); end
        end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        @(posedge clk); #1;
        idle_inputs();
        bus.addr = 14'h1010; bus.rd_req = 1'b1;
        @(posedge clk); #1;
        bus.rd_req = 1'b0; bus.addr = 14'h2468;
        @(posedge clk); #3;
        rstb = 1'b0;
        #1;
        n_checks++; if ({bus.rd_ready, bus.wr_ready, bus.err, bus.t_rd_en, bus.t_wr_en, bus.t_wr_be, bus.t_wr_data, bus.rd_data} !== '0) begin n_fail++; $display("FAIL rst_mid_outputs got nonzero rd=%b wr=%b err=%b", bus.rd_ready, bus.wr_ready, bus.err); end
        n_checks++; if (bus.t_addr !== exp_offsets(14'h2468)) begin n_fail++; $display("FAIL rst_mid_t_addr got %h want %h", bus.t_addr, exp_offsets(14'h2468)); end
        @(posedge clk); #1;
        bus.t_rd_ready = 4'hF;
        @(negedge clk);
        n_checks++; if (bus.rd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ready got %b want 0", bus.rd_ready); end
        rstb = 1'b1;
        drive_txn(1'b0, 1'b1, 14'h1010, 4'h0, 32'h0, 32'h7777_8888, 2, 1'b0, 1'b0, o);
        n_checks++; if ({o.done == 2, o.rd_en, o.err, o.rdata} !== {1'b1, 4'b0010, 1'b0, 32'h7777_8888}) begin n_fail++; $display("FAIL rst_mid_recover got done=%0d en=%b err=%b %h", o.done, o.rd_en, o.err, o.rdata); end
    endtask

    task automatic test_random();
        obs_t o;
        bit wr, rd, noise, hit;
        logic [13:0] a;
        logic [3:0] be;
        logic [31:0] wd, td;
        int dly, sel, e_done, pick;
        logic e_err;
        for (int n = 0; n < 30; n++) begin
            pick = $urandom_range(0, 3);
            wr = (pick == 1) || (pick == 2); rd = (pick != 1);
            a = 14'($urandom); be = 4'($urandom); wd = $urandom; td = $urandom;
            noise = 1'($urandom);
            pick = $urandom_range(0, 9);
            dly = (pick < 6) ? pick + 1 : (pick == 6) ? 0 : (pick == 7) ? int'(TMO) : (pick == 8) ? int'(TMO) + 1 : int'(TMO) - 1;
            drive_txn(wr, rd, a, be, wd, td, dly, noise, 1'b0, o);
            sel = model_sel(a);
            hit = (sel >= 0);
            if (!hit) begin e_done = 1; e_err = 1'b1; end
            else if ((dly >= 1) && (dly <= int'(TMO))) begin e_done = dly; e_err = 1'b0; end
            else begin e_done = int'(TMO); e_err = 1'b1; end
            n_checks++; if (o.rd_en !== ((hit && !wr) ? 4'b0001 << sel : 4'b0000)) begin n_fail++; $display("FAIL rnd%0d_rd_en a=%h got %b", n, a, o.rd_en); end
            n_checks++; if (o.wr_en !== ((hit && wr) ? 4'b0001 << sel : 4'b0000)) begin n_fail++; $display("FAIL rnd%0d_wr_en a=%h got %b", n, a, o.wr_en); end
            n_checks++; if (o.wbe !== ((hit && wr) ? 16'(be) << (4 * sel) : 16'h0)) begin n_fail++; $display("FAIL rnd%0d_wr_be got %h", n, o.wbe); end
            n_checks++; if (o.taddr !== exp_offsets(a)) begin n_fail++; $display("FAIL rnd%0d_t_addr got %h want %h", n, o.taddr, exp_offsets(a)); end
            n_checks++; if (o.done !== e_done) begin n_fail++; $display("FAIL rnd%0d_latency got %0d want %0d", n, o.done, e_done); end
            n_checks++; if ({o.wr_rdy, o.rd_rdy, o.err, o.stray} !== {wr, !wr, e_err, 1'b0}) begin n_fail++; $display("FAIL rnd%0d_resp got %b want %b", n, {o.wr_rdy, o.rd_rdy, o.err, o.stray}, {wr, !wr, e_err, 1'b0}); end
            if (e_err || !wr) begin
                n_checks++; if (o.rdata !== (e_err ? DEAD : td)) begin n_fail++; $display("FAIL rnd%0d_rd_data got %h want %h", n, o.rdata, e_err ? DEAD : td); end
            end
            if (hit) begin
                n_checks++; if (o.w_taddr !== exp_offsets(a)) begin n_fail++; $display("FAIL rnd%0d_wait_t_addr got %h want %h", n, o.w_taddr, exp_offsets(a)); end
            end
            if (hit && wr) begin
                n_checks++; if ({o.wdata, o.w_wdata} !== {wd, wd}) begin n_fail++; $display("FAIL rnd%0d_t_wr_data got %h/%h want %h", n, o.wdata, o.w_wdata, wd); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_ram();
        test_write_wait();
        test_decode_err();
        test_timeout();
        test_simultaneous();
        test_req_during_wait();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
